// File: rtl/rr_arb4_sel.sv
// Four-channel round-robin arbiter driving a downstream 4:1 mux select.
// Each grant lasts BURST_LEN accepted beats or until the owner drops req.
module rr_arb4_sel #(
    parameter  int BURST_LEN = 4,
    localparam int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic [3:0]       grant,
    output logic             out_valid,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n, sel_n;
    logic [3:0]       grant_n;
    logic [CNT_W-1:0] cnt_n;
    logic             beat, release_grant;

    // First requesting channel scanning upward from p, wrapping mod 4.
    function automatic logic [1:0] arb(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        arb   = p;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                arb   = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign busy          = (state == GRANT);
    assign out_valid     = busy & req[sel];
    assign beat          = out_valid & out_ready;
    assign release_grant = busy & (~req[sel] | (beat & (beat_cnt == LAST_CNT)));

    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        cnt_n   = beat_cnt;
        if (state == IDLE) begin
            if (req != 4'b0000) begin
                state_n = GRANT;
                sel_n   = arb(req, ptr);
                cnt_n   = '0;
            end
        end else if (release_grant) begin
            // Old owner drops to lowest priority; re-arbitrate with no bubble.
            ptr_n = sel + 2'd1;
            cnt_n = '0;
            if (req != 4'b0000) begin
                sel_n = arb(req, sel + 2'd1);
            end else begin
                state_n = IDLE;
                sel_n   = 2'd0;
            end
        end else if (beat) begin
            cnt_n = beat_cnt + CNT_W'(1);
        end
        grant_n = (state_n == GRANT) ? (4'b0001 << sel_n) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 2'd0;
            grant    <= 4'b0000;
            beat_cnt <= '0;
            ptr      <= 2'd0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            grant    <= grant_n;
            beat_cnt <= cnt_n;
            ptr      <= ptr_n;
        end
    end

endmodule
